// File: rtl/pipe_stage_chain_pkg.sv
// rtl/pipe_stage_chain_pkg.sv - shared pipeline slice state and boundary payload types
package pipe_stage_chain_pkg;

    typedef enum logic [1:0] {
        SLICE_EMPTY = 2'd0,
        SLICE_HALF  = 2'd1,
        SLICE_FULL  = 2'd2
    } slice_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

endpackage

// File: rtl/pipe_skid_slice.sv
// rtl/pipe_skid_slice.sv - one valid/ready slice with main and skid registers
module pipe_skid_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    import pipe_stage_chain_pkg::*;

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_fire;
    slice_state_t     state;

    // Ready comes only from registered state, so no ready path crosses slices.
    assign in_ready_o  = !skid_valid && !flush_i;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = main_valid && out_ready_i;

    always_comb begin
        state = SLICE_EMPTY;
        if (skid_valid) begin
            state = SLICE_FULL;
        end else if (main_valid) begin
            state = SLICE_HALF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            case (state)
                SLICE_EMPTY: begin
                    if (in_fire) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data_i;
                    end
                end
                SLICE_HALF: begin
                    if (in_fire && out_fire) begin
                        main_data <= in_data_i;
                    end else if (in_fire) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data_i;
                    end else if (out_fire) begin
                        main_valid <= 1'b0;
                    end
                end
                SLICE_FULL: begin
                    if (out_fire) begin
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - cascaded skid slices with flush and saturating stall counter
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o
);
    import pipe_stage_chain_pkg::*;

    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] dat [STAGES+1];

    assign vld[0]      = in_valid_i;
    assign dat[0]      = in_data_i;
    assign in_ready_o  = rdy[0];
    assign out_valid_o = vld[STAGES];
    assign out_data_o  = dat[STAGES];
    assign rdy[STAGES] = out_ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipe_skid_slice #(.WIDTH(WIDTH)) u_slice (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .flush_i     (flush_i),
            .in_valid_i  (vld[k]),
            .in_ready_o  (rdy[k]),
            .in_data_i   (dat[k]),
            .out_valid_o (vld[k+1]),
            .out_ready_i (rdy[k+1]),
            .out_data_o  (dat[k+1])
        );
    end

    // Survives flush on purpose: it measures downstream backpressure history.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule
